// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and constants for the MCU run/step control blocks.
package mcu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } step_state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Board-side signals of the run/step controller: slow clock, mode inputs, CPU enable and debug outputs.
interface cpu_step_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             sclk;
   logic             run;
   logic             step_btn;
   logic             halt_req;
   logic             cpu_en;
   logic [1:0]       state;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output sclk, run, step_btn, halt_req,
      input  cpu_en, state, cycle_count
   );

   modport slave (
      input  sclk, run, step_btn, halt_req,
      output cpu_en, state, cycle_count
   );
endinterface

// File: rtl/cpu_step_ctrl_button_debouncer.sv
// Button debouncer sampled on an external strobe; emits a one-cycle pulse when the accepted level rises.
module button_debouncer #(
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic sample_en,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise
);
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          rise_q, rise_d;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      if (sample_en) begin
         if (btn_in != stable_q) begin
            // this sample is the DEBOUNCE_TICKS-th consecutive differing one
            if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
               stable_d = btn_in;
               cnt_d    = '0;
               rise_d   = btn_in;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
      end
   end

   assign btn_level = stable_q;
   assign btn_rise  = rise_q;
endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/single-step controller: turns rising edges of the divided clock into one-cycle CPU
// clock-enable pulses, gated by run, debounced step and break request.
module cpu_step_ctrl
   import mcu_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int CNT_W          = 16
) (
   input  logic            clk,
   input  logic            reset,
   cpu_step_ctrl_if.slave  bus
);
   // bit 0 is the first sync stage; the top bit is the edge-detect history flop
   logic [SYNC_STAGES:0]   sclk_sh_q, sclk_sh_d;
   logic [SYNC_STAGES-1:0] run_sh_q, run_sh_d;
   logic [SYNC_STAGES-1:0] btn_sh_q, btn_sh_d;
   step_state_t            state_q, state_d;
   logic                   cpu_en_q, cpu_en_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic tick;
   logic run_s;
   logic btn_level;
   logic btn_rise;
   logic step_req;

   assign tick     = sclk_sh_q[SYNC_STAGES-1] & ~sclk_sh_q[SYNC_STAGES];
   assign run_s    = run_sh_q[SYNC_STAGES-1];
   assign step_req = btn_rise & btn_level;

   button_debouncer #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
   ) u_step_db (
      .clk       (clk),
      .reset     (reset),
      .sample_en (tick),
      .btn_in    (btn_sh_q[SYNC_STAGES-1]),
      .btn_level (btn_level),
      .btn_rise  (btn_rise)
   );

   always_comb begin
      sclk_sh_d = {sclk_sh_q[SYNC_STAGES-1:0], bus.sclk};
      run_sh_d  = {run_sh_q[SYNC_STAGES-2:0], bus.run};
      btn_sh_d  = {btn_sh_q[SYNC_STAGES-2:0], bus.step_btn};
   end

   always_comb begin
      state_d  = state_q;
      cpu_en_d = 1'b0;
      case (state_q)
         ST_HALT: begin
            if (run_s)         state_d = ST_RUN;
            else if (step_req) state_d = ST_STEP;
         end
         ST_RUN: begin
            if (bus.halt_req)  state_d  = ST_BREAK;
            else if (!run_s)   state_d  = ST_HALT;
            else if (tick)     cpu_en_d = 1'b1;
         end
         ST_STEP: begin
            if (bus.halt_req) begin
               state_d = ST_BREAK;
            end else if (tick) begin
               cpu_en_d = 1'b1;
               state_d  = ST_HALT;
            end
         end
         ST_BREAK: begin
            if (!run_s)        state_d = ST_HALT;
         end
         default:              state_d = ST_HALT;
      endcase
      cnt_d = cnt_q + CNT_W'(cpu_en_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sh_q <= '0;
         run_sh_q  <= '0;
         btn_sh_q  <= '0;
         state_q   <= ST_HALT;
         cpu_en_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sclk_sh_q <= sclk_sh_d;
         run_sh_q  <= run_sh_d;
         btn_sh_q  <= btn_sh_d;
         state_q   <= state_d;
         cpu_en_q  <= cpu_en_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.cpu_en      = cpu_en_q;
   assign bus.state       = state_q;
   assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: scenario table, directed corner sequences and random stimulus
// against a cycle-level reference model built from delayed-sample rules.
module tb_cpu_step_ctrl;
   import mcu_ctrl_pkg::*;

   localparam int DEB = 4;

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic sclk     = 1'b0;
   logic run      = 1'b0;
   logic step_btn = 1'b0;
   logic halt_req = 1'b0;

   always #5 clk = ~clk;

   cpu_step_ctrl_if #(.CNT_W(16)) bus16 ();
   cpu_step_ctrl_if #(.CNT_W(4))  bus4 ();

   assign bus16.sclk = sclk;  assign bus16.run = run;
   assign bus16.step_btn = step_btn;  assign bus16.halt_req = halt_req;
   assign bus4.sclk = sclk;   assign bus4.run = run;
   assign bus4.step_btn = step_btn;   assign bus4.halt_req = halt_req;

   cpu_step_ctrl #(.DEBOUNCE_TICKS(DEB), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .bus(bus16));
   cpu_step_ctrl #(.DEBOUNCE_TICKS(DEB), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: every synchronised input is the raw input as it stood two edges
   // earlier; a tick is "sclk high two edges ago, low three edges ago".
   bit          m_sclk_hist[3];   // [k] = sclk sampled k+1 edges ago
   bit          m_run_hist[2];
   bit          m_btn_hist[2];
   int          m_db_cnt;
   bit          m_stable, m_rise;
   int          m_state;          // 0 halt, 1 run, 2 step, 3 break
   bit          m_en;
   int unsigned m_cnt;
   bit          m_tick, m_req, m_run_s, m_btn_s;

   always @(posedge clk) begin
      if (reset) begin
         m_sclk_hist = '{0, 0, 0};
         m_run_hist  = '{0, 0};
         m_btn_hist  = '{0, 0};
         m_db_cnt = 0; m_stable = 0; m_rise = 0;
         m_state = 0; m_en = 0; m_cnt = 0;
      end else begin
         m_tick  = m_sclk_hist[1] && !m_sclk_hist[2];
         m_run_s = m_run_hist[1];
         m_btn_s = m_btn_hist[1];
         m_req   = m_rise;
         m_rise  = 0;
         if (m_tick) begin
            if (m_btn_s != m_stable) begin
               m_db_cnt++;
               if (m_db_cnt == DEB) begin
                  m_stable = m_btn_s; m_rise = m_btn_s; m_db_cnt = 0;
               end
            end else m_db_cnt = 0;
         end
         m_en = 0;
         if (m_state == 0) begin
            if (m_run_s) m_state = 1; else if (m_req) m_state = 2;
         end else if (m_state == 1) begin
            if (halt_req) m_state = 3; else if (!m_run_s) m_state = 0; else m_en = m_tick;
         end else if (m_state == 2) begin
            if (halt_req) m_state = 3; else if (m_tick) begin m_en = 1; m_state = 0; end
         end else begin
            if (!m_run_s) m_state = 0;
         end
         if (m_en) m_cnt++;
         m_sclk_hist[2] = m_sclk_hist[1]; m_sclk_hist[1] = m_sclk_hist[0]; m_sclk_hist[0] = sclk;
         m_run_hist[1] = m_run_hist[0];   m_run_hist[0] = run;
         m_btn_hist[1] = m_btn_hist[0];   m_btn_hist[0] = step_btn;
      end
   end

   always @(negedge clk) begin
      check("model_cpu_en",   32'(bus16.cpu_en), 32'(m_en));
      check("model_state",    32'(bus16.state), 32'(m_state));
      check("model_count16",  32'(bus16.cycle_count), m_cnt & 32'hFFFF);
      check("model_count4",   32'(bus4.cycle_count), m_cnt & 32'hF);
   end

   // Per-cycle driver: advances one clock, records pulses/states, then moves sclk.
   int cyc_no = 0, sclk_half = 0, ph = 0, last_rise = -100, pulses = 0;
   bit prev_en = 0, track_lat = 0, track_seq = 0;
   int seq[$];

   task automatic cyc();
      @(posedge clk); #1;
      cyc_no++;
      if (bus16.cpu_en === 1'b1) begin
         pulses++;
         if (track_lat) begin
            check("pulse_latency", 32'(cyc_no - last_rise), 32'd3);
            check("pulse_width", 32'(prev_en), 32'd0);
         end
      end
      prev_en = bus16.cpu_en;
      if (track_seq && (seq.size() == 0 || seq[$] != int'(bus16.state)))
         seq.push_back(int'(bus16.state));
      if (sclk_half > 0) begin
         ph++;
         if (ph >= sclk_half) begin
            ph = 0; sclk = ~sclk;
            if (sclk) last_rise = cyc_no;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1; sclk_half = 0; ph = 0; sclk = 0;
      run = 0; step_btn = 0; halt_req = 0;
      cyc(); cyc();
      reset = 0;
   endtask

   task automatic press(input int hold, input int rel);
      step_btn = 1; cyc(); step_btn = 0; cyc(); step_btn = 1;
      repeat (hold) cyc();
      step_btn = 0;
      repeat (rel) cyc();
   endtask

   typedef struct {
      int half; bit run_v; int periods; int exp_pulses; int exp_state;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int exp_seq[3];

      vecs[0] = '{4, 1'b1, 10, 10, 1};
      vecs[1] = '{2, 1'b1, 12, 12, 1};
      vecs[2] = '{3, 1'b1,  7,  7, 1};
      vecs[3] = '{5, 1'b1,  4,  4, 1};
      vecs[4] = '{4, 1'b0,  6,  0, 0};
      vecs[5] = '{2, 1'b0,  5,  0, 0};

      // reset held with sclk toggling and run high
      run = 1; sclk_half = 2;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("reset_cpu_en", 32'(bus16.cpu_en), 32'd0);
         check("reset_state", 32'(bus16.state), 32'(ST_HALT));
         check("reset_count", 32'(bus16.cycle_count), 32'd0);
      end
      reset = 0; sclk_half = 0; sclk = 0;
      cyc(); cyc(); cyc();
      check("run_after_reset", 32'(bus16.state), 32'(ST_RUN));

      // table: steady sclk with run fixed
      for (int v = 0; v < 6; v++) begin
         do_reset();
         run = vecs[v].run_v;
         repeat (4) cyc();
         pulses = 0; track_lat = 1; ph = 0; sclk_half = vecs[v].half;
         repeat (2 * vecs[v].half * vecs[v].periods) cyc();
         sclk_half = 0;
         repeat (4) cyc();
         track_lat = 0;
         check("tbl_pulses", 32'(pulses), 32'(vecs[v].exp_pulses));
         check("tbl_count", 32'(bus16.cycle_count), 32'(vecs[v].exp_pulses));
         check("tbl_state", 32'(bus16.state), 32'(vecs[v].exp_state));
      end

      // single step with bounce, then a too-short press
      do_reset();
      sclk_half = 4;
      repeat (10) cyc();
      pulses = 0; seq.delete(); track_seq = 1;
      seq.push_back(int'(bus16.state));
      press(48, 48);
      track_seq = 0;
      exp_seq = '{0, 2, 0};
      check("step_pulses", 32'(pulses), 32'd1);
      check("step_seq_len", 32'(seq.size()), 32'd3);
      for (int i = 0; i < 3 && i < seq.size(); i++)
         check("step_seq", 32'(seq[i]), 32'(exp_seq[i]));
      pulses = 0;
      step_btn = 1; repeat (16) cyc(); step_btn = 0; repeat (48) cyc();
      check("short_press_pulses", 32'(pulses), 32'd0);
      check("short_press_state", 32'(bus16.state), 32'(ST_HALT));

      // break: halt_req coincident with tick
      do_reset();
      run = 1; sclk_half = 4;
      repeat (20) cyc();
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc();
         found = (last_rise == cyc_no);
      end
      cyc(); cyc();
      halt_req = 1;
      cyc();
      halt_req = 0;
      check("break_no_pulse", 32'(bus16.cpu_en), 32'd0);
      check("break_state", 32'(bus16.state), 32'(ST_BREAK));
      pulses = 0;
      press(48, 48);
      check("break_step_ignored", 32'(pulses), 32'd0);
      check("break_hold_state", 32'(bus16.state), 32'(ST_BREAK));
      run = 0;
      cyc(); cyc(); cyc();
      check("break_to_halt", 32'(bus16.state), 32'(ST_HALT));

      // counter wrap on the 4-bit instance
      do_reset();
      run = 1;
      repeat (4) cyc();
      pulses = 0; ph = 0; sclk_half = 2;
      repeat (17 * 4) cyc();
      sclk_half = 0;
      repeat (4) cyc();
      check("wrap_pulses", 32'(pulses), 32'd17);
      check("wrap_count4", 32'(bus4.cycle_count), 32'd1);
      check("wrap_count16", 32'(bus16.cycle_count), 32'd17);

      // reset while in STEP, before the tick that would pulse
      do_reset();
      sclk_half = 4;
      step_btn = 1;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         cyc();
         found = (bus16.state == ST_STEP);
      end
      check("step_state_reached", 32'(found), 32'd1);
      step_btn = 0; reset = 1;
      cyc();
      reset = 0;
      check("midstep_cpu_en", 32'(bus16.cpu_en), 32'd0);
      check("midstep_state", 32'(bus16.state), 32'(ST_HALT));
      pulses = 0;
      repeat (60) cyc();
      check("midstep_pulses", 32'(pulses), 32'd0);
      check("midstep_count", 32'(bus16.cycle_count), 32'd0);

      // random mix, compared cycle by cycle with the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) sclk_half = $urandom_range(2, 5);
         if ($urandom_range(0, 149) == 0) run = ~run;
         if ($urandom_range(0, 19) == 0) step_btn = ~step_btn;
         halt_req = (m_state == 1 || m_state == 2) && ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 699) == 0);
         cyc();
      end
      reset = 0; halt_req = 0;
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Run/single-step controller for the multicycle MCU, placed directly downstream of `clock_divider`. It samples the divided `sclk` in the system clock domain and detects its rising edges. It turns each edge into a one-cycle `cpu_en` clock-enable for the CPU, gated by run/step/break mode. This lets the board run the CPU at the slow rate, halt it, or advance it one cycle per debounced button press.

## Interface
- `DEBOUNCE_TICKS`, default 4: consecutive sclk edges a changed button level must persist before it is accepted (≥1).
- `CNT_W`, default 16: width of the enabled-cycle counter.

- `clk`  in  1  system clock; same clock that drives `clock_divider`.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  divided clock from `clock_divider`, treated as data.
- `run`  in  1  run switch, level; assumed quasi-static, passed through a 2-FF sync.
- `step_btn`  in  1  raw single-step push button.
- `halt_req`  in  1  CPU break request (e.g. ebreak decoded); synchronous to `clk`.
- `cpu_en`  out  1  one-`clk` clock-enable pulse to the CPU.
- `state`  out  2  current controller state, for LEDs/debug.
- `cycle_count`  out  CNT_W  number of `cpu_en` pulses issued since reset.

## Operation
- `sclk` passes through a 2-FF sync (s1, s2) plus a history flop s3.
  - `tick = s2 & ~s3`.
  - `run` and `step_btn` use their own 2-FF syncs.
- Debounce runs only on `tick`:
  - If synced button ≠ stable level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_TICKS, stable takes the new level and the counter clears.
  - A rising edge of stable produces `step_req` for exactly one `clk` cycle.
- FSM (`state` encoding: HALT=0, RUN=1, STEP=2, BREAK=3):
  - HALT: `run` → RUN. Otherwise `step_req` → STEP. Otherwise stay.
  - RUN: `halt_req` → BREAK (no pulse that cycle). Else `run`=0 → HALT. Else pulse `cpu_en` on `tick`.
  - STEP: `halt_req` → BREAK, no pulse. Else on `tick`, pulse `cpu_en` and go to HALT.
  - BREAK: `cpu_en` held 0. `run`=0 → HALT. `step_req` is ignored.
- Priority in every state: reset > `halt_req` > `run` > `step_req` > `tick`.
- `step_req` in RUN, STEP or BREAK is dropped, not queued.
- `cycle_count` increments with each `cpu_en` pulse and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (synchronous, at the edge where `reset`=1):
  - `cpu_en`=0, `state`=HALT, `cycle_count`=0.
  - All sync flops, debounce counter and stable level = 0.
- Reset mid-STEP or mid-RUN: any pending pulse is discarded; `cpu_en` is 0 in the cycle after the reset edge.
- `cpu_en` latency from `sclk` rise:
  - Edge E0: `sclk` captured into s1.
  - Edge E1: s2=1, so `tick` is high for that cycle.
  - Edge E2: registered `cpu_en`=1, for exactly one cycle.
- Each `sclk` period yields at most one pulse, regardless of MAX_COUNT.
- The minimum supported `sclk` half-period is 2 `clk` cycles; faster inputs alias.
- `state` is registered and updates on the same edge that registers `cpu_en`.
- `run` and `step` propagation:
  - `run` assertion reaches the FSM 2 cycles after the input changes.
  - The first RUN pulse requires a subsequent `tick`.
- `halt_req` is not synchronized. If asserted in the same cycle as `tick` in RUN, no pulse is issued.

## Structure
- Shared package `mcu_ctrl_pkg`:
  - `typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP, ST_BREAK} step_state_t`.
  - `localparam SYNC_STAGES = 2`.
- One sub-module, `button_debouncer` (ports `clk`, `reset`, `sample_en`, `btn_in`, `btn_level`, `btn_rise`; parameter DEBOUNCE_TICKS). It is reused later for other board buttons.
- Sync chains, edge detect, FSM and counter stay in `cpu_step_ctrl`.

## Test plan
- **Reset:** hold `reset` 3 cycles with `sclk` toggling and `run`=1 → `cpu_en`=0, `state`=0, `cycle_count`=0 throughout. After release, `state`=1 within 3 cycles.
- **Run rate:** `sclk` period 8 `clk`, `run`=1 for 80 cycles → 10 `cpu_en` pulses, each 1 cycle wide, each 3 edges after `sclk` rise; `cycle_count`=10.
- **Single step:** `run`=0, press `step_btn` with 2-cycle bounce, then stable for 5 ticks (DEBOUNCE_TICKS=4) → exactly 1 pulse and `state` sequence HALT→STEP→HALT. A press shorter than 4 ticks → 0 pulses.
- **Break:** RUN with `halt_req` asserted in the same cycle as `tick` → no pulse, `state`=3. Step presses are then ignored. `run` 1→0 → `state`=0.
- **Counter wrap:** with CNT_W=4, 17 pulses → `cycle_count`=1.
- **Reset mid-step:** assert `reset` while `state`=STEP before `tick` → no pulse, `state`=HALT, `cycle_count` unchanged at 0.
